// File: rtl/onchip_ram_loader_pkg.sv
// Shared definitions for the on-chip RAM loader: FSM states, lane geometry
// and the helper that turns a filled-lane count into a RAM byteenable.
// No logic of its own; imported by the packer and the top.
package onchip_ram_loader_pkg;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    DRAIN,
    DONE,
    VERIFY_RD,
    VERIFY_CMP
  } state_t;

  // Byteenable for a word whose lanes 0..n-1 hold valid bytes (n = 0..4).
  function automatic logic [LANES-1:0] lane_mask(input logic [2:0] n);
    logic [LANES:0] ones;
    ones = 5'd1 << n;
    return LANES'(ones - 5'd1);
  endfunction

endpackage

// File: rtl/loader_byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word, one lane per byte.
// Latency: byte lands in the word register on the accepting clock edge.
// Backpressure: none internally; the top stops accepting once full is high.
module loader_byte_packer
  import onchip_ram_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    accept,
  input  logic [BYTE_W-1:0]       data,
  output logic [LANES*BYTE_W-1:0] word,
  output logic [LANES-1:0]        byteenable,
  output logic [2:0]              count,
  output logic                    full
);

  assign full       = (count == 3'(LANES));
  assign byteenable = lane_mask(count);

  // Drop each accepted byte into the next free lane; clear only rewinds the
  // lane index so unused lanes of a partial word keep stale data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      word  <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (accept && !full) begin
      word[{count[1:0], 3'b000} +: BYTE_W] <= data;
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/onchip_ram_loader.sv
// Avalon-MM write master loading a byte stream into on-chip RAM from a base word address.
// Latency: a word is written 1 cycle after its completing byte; optional build
// LOADER_READBACK_VERIFY_EN adds a read-back compare (2 extra cycles per word).
// Backpressure: in_ready is high only while collecting or draining bytes.
module onchip_ram_loader
  import onchip_ram_loader_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 0,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  output logic              ram_clken,
  input  logic [31:0]       ram_readdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow,
  output logic              timeout
`ifdef LOADER_READBACK_VERIFY_EN
  , output logic            verify_err
`endif
);

`ifdef LOADER_READBACK_VERIFY_EN
  localparam state_t WORD_END = VERIFY_CMP;
`else
  localparam state_t WORD_END = WRITE;
`endif
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t              state, state_nxt, after_word;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    tmo_cnt;
  logic                end_seen;
  logic                accept, tmo_hit, at_top, pk_clear, pk_full;
  logic [31:0]         pk_word;
  logic [3:0]          pk_be;
  logic [2:0]          pk_count;

  assign accept         = in_valid && in_ready;
  assign in_ready       = (state == COLLECT) || (state == DRAIN);
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign ram_clken      = 1'b1;
  assign ram_address    = base_q + word_count[ADDR_W-1:0];
  assign at_top         = (ram_address == {ADDR_W{1'b1}});
  assign ram_write      = (state == WRITE);
  assign ram_chipselect = (state == WRITE) || (state == VERIFY_RD);
  assign ram_byteenable = ram_chipselect ? pk_be : 4'h0;
  assign ram_writedata  = pk_word;
  assign tmo_hit        = (TIMEOUT_CYC > 0) && (state == COLLECT) && !in_valid &&
                          (tmo_cnt == TMO_LAST);
  assign pk_clear       = ((state == IDLE) && start) || (state == WORD_END);

  loader_byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (pk_clear),
    .accept     (accept && (state == COLLECT)),
    .data       (in_data),
    .word       (pk_word),
    .byteenable (pk_be),
    .count      (pk_count),
    .full       (pk_full)
  );

  // Where to go once a word is committed: finish, stop at the RAM top, or keep collecting.
  always_comb begin
    after_word = COLLECT;
    if (end_seen)    after_word = DONE;
    else if (at_top) after_word = DRAIN;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start) state_nxt = COLLECT;
      COLLECT: begin
        if (accept && (in_last || pk_count == 3'd3)) state_nxt = WRITE;
        else if (tmo_hit) state_nxt = (pk_count != 3'd0) ? WRITE : DONE;
      end
`ifdef LOADER_READBACK_VERIFY_EN
      WRITE:      state_nxt = VERIFY_RD;
      VERIFY_RD:  state_nxt = VERIFY_CMP;
      VERIFY_CMP: state_nxt = after_word;
`else
      WRITE:      state_nxt = after_word;
`endif
      DRAIN:      if (accept && in_last) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Load bookkeeping: base latch, word count, end-of-image and sticky status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      word_count <= '0;
      end_seen   <= 1'b0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base_q     <= base_addr;
          word_count <= '0;
          end_seen   <= 1'b0;
          overflow   <= 1'b0;
          timeout    <= 1'b0;
          tmo_cnt    <= '0;
        end
        COLLECT: begin
          if (accept) begin
            tmo_cnt <= '0;
            if (in_last) end_seen <= 1'b1;
          end else if (tmo_hit) begin
            timeout  <= 1'b1;
            end_seen <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        DRAIN: if (accept) overflow <= 1'b1;
        default: ;
      endcase
      if (state == WORD_END) word_count <= word_count + (ADDR_W+1)'(1);
    end
  end

`ifdef LOADER_READBACK_VERIFY_EN
  logic [31:0] lane_bits;
  logic        rd_mismatch;

  // Expand the byteenable so only written lanes take part in the compare.
  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < LANES; i++) lane_bits[i*BYTE_W +: BYTE_W] = {BYTE_W{pk_be[i]}};
  end
  assign rd_mismatch = |((ram_readdata ^ pk_word) & lane_bits);

  // Sticky read-back error, cleared by the next accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          verify_err <= 1'b0;
    else if ((state == IDLE) && start)     verify_err <= 1'b0;
    else if ((state == VERIFY_CMP) && rd_mismatch) verify_err <= 1'b1;
  end
`else
  logic unused_readdata;
  assign unused_readdata = ^ram_readdata;
`endif

endmodule

// File: tb/tb_onchip_ram_loader.sv
// Self-checking bench for onchip_ram_loader: RAM model, image-level write model, per-cycle compare.
// Latency: checks each write arrives 1 cycle after its completing byte (timeout flush after the idle window).
// Backpressure: bytes are held until in_ready is seen, with bounded waits.
module tb_onchip_ram_loader;

  localparam int ADDR_W = 10;
  localparam int TMO    = 8;

  typedef struct {
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
    int          gap;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready, ram_chipselect, ram_write, ram_clken, busy, done, overflow, timeout;
  logic [9:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata, ram_readdata;
  logic [10:0] word_count;
`ifdef LOADER_READBACK_VERIFY_EN
  logic        verify_err;
`endif

  logic [31:0] mem [1024];
  logic        corrupt = 1'b0;
  logic [7:0]  bytes [$];
  wr_t         exp_q [$];
  int          exp_wc;
  logic        exp_ovf, exp_tmo;
  int          n_checks = 0;
  int          n_pass = 0;
  int          neg_idx = 0;
  int          last_acc_neg = 0;

  onchip_ram_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO), .CNT_W(16)) dut (
`ifdef LOADER_READBACK_VERIFY_EN
    .verify_err     (verify_err),
`endif
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .ram_address    (ram_address),
    .ram_byteenable (ram_byteenable),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata),
    .busy           (busy),
    .done           (done),
    .word_count     (word_count),
    .overflow       (overflow),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] lanebits(input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{be[i]}};
    return r;
  endfunction

  // Single-port RAM: byte-lane writes, registered read with optional bit-5 fault at 0x020.
  always @(posedge clk) begin
    if (ram_chipselect && ram_write)
      for (int i = 0; i < 4; i++)
        if (ram_byteenable[i]) mem[ram_address][8*i +: 8] <= ram_writedata[8*i +: 8];
    ram_readdata <= mem[ram_address] ^ ((corrupt && ram_address == 10'h020) ? 32'h20 : 32'h0);
  end

  // Image-level model: consecutive 4-byte groups go to base, base+1, ... until the RAM top.
  task automatic model_load(input int base, input bit tmo_mode);
    int n, cap, nw;
    n       = bytes.size();
    cap     = 1024 - base;
    nw      = (n + 3) / 4;
    exp_wc  = (nw < cap) ? nw : cap;
    exp_ovf = (n > cap * 4);
    exp_tmo = tmo_mode;
    for (int w = 0; w < exp_wc; w++) begin
      wr_t e;
      e.addr = 10'(base + w);
      e.data = '0;
      e.be   = '0;
      e.gap  = (tmo_mode && w == exp_wc - 1 && (n % 4) != 0) ? TMO + 1 : 1;
      for (int b = 0; b < 4; b++)
        if (4*w + b < n) begin
          e.data[8*b +: 8] = bytes[4*w + b];
          e.be[b] = 1'b1;
        end
      exp_q.push_back(e);
    end
  endtask

  // Per-cycle compare of every RAM write against the model queue.
  always @(negedge clk) begin
    wr_t w;
    if (reset_n) begin
      neg_idx++;
      if (ram_chipselect !== ram_write) chk("cs_vs_write", ram_chipselect, ram_write);
      if (ram_write) begin
        if (exp_q.size() == 0) chk("unexpected_write", ram_address, 32'hFFFF_FFFF);
        else begin
          w = exp_q.pop_front();
          chk("wr_addr", ram_address, w.addr);
          chk("wr_be", ram_byteenable, w.be);
          chk("wr_data", ram_writedata & lanebits(w.be), w.data);
          chk("wr_latency", neg_idx - last_acc_neg, w.gap);
        end
      end
      if (in_valid && in_ready) last_acc_neg = neg_idx;
    end
  end

  task automatic fill_rand(input int n);
    bytes.delete();
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
  endtask

  // Present one byte until accepted; returns cycles waited (0 if the bound expired).
  task automatic send_byte(input logic [7:0] d, input bit last, input bit glitch, output int cyc);
    bit acc;
    acc = 1'b0;
    cyc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = in_ready;
      if (glitch) begin start = 1'b1; base_addr = 10'($urandom); end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) begin chk("byte_accept_bound", 0, 1); cyc = 0; end
  endtask

  task automatic run_load(input int base, input int maxgap, input bit tmo_mode,
                          input bit together, input bit glitch);
    int n, cyc, guard;
    n = bytes.size();
    model_load(base, tmo_mode);
    base_addr = 10'(base);
    start     = 1'b1;
    if (together && n > 0) begin
      in_valid = 1'b1;
      in_data  = bytes[0];
      in_last  = (n == 1) && !tmo_mode;
      @(negedge clk);
      chk("in_ready_with_start", in_ready, 0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = 10'($urandom);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[i], (i == n - 1) && !tmo_mode, glitch && (i == 2), cyc);
      if (together && i == 0) chk("first_byte_next_cycle", cyc, 1);
      if (i != n - 1) begin
        repeat ($urandom_range(maxgap, 0)) @(posedge clk);
        #1;
      end
    end
    guard = 0;
    do begin @(negedge clk); guard++; end while (!done && guard < 200);
    if (!done) chk("done_bound", 0, 1);
    else begin
      chk("word_count", word_count, exp_wc);
      chk("overflow", overflow, exp_ovf);
      chk("timeout", timeout, exp_tmo);
      chk("busy_in_done", busy, 1);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_not_busy", busy, 0);
      chk("writes_outstanding", exp_q.size(), 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cs"}, ram_chipselect, 0);
    chk({tag, "_write"}, ram_write, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_tmo"}, timeout, 0);
    chk({tag, "_addr"}, ram_address, 0);
    chk({tag, "_be"}, ram_byteenable, 0);
    chk({tag, "_wdata"}, ram_writedata, 0);
    chk({tag, "_wc"}, word_count, 0);
    chk({tag, "_clken"}, ram_clken, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, guard, base;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    #1 reset_n = 1'b0;
    #2 chk_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Five bytes from 0x010: one full word and one single-lane word.
    bytes = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_load(16, 0, 0, 0, 0);
    chk("t1_mem010", mem[16], 32'h44332211);
    chk("t1_mem011_lane0", mem[17][7:0], 8'h55);
    chk("t1_wc_literal", word_count, 2);

    // Twelve bytes from 0x3FE: two words fit, four bytes drained.
    fill_rand(12);
    run_load(10'h3FE, 1, 0, 0, 0);
    chk("t2_ovf_literal", overflow, 1);
    chk("t2_wc_literal", word_count, 2);

    // Three bytes then silence: partial flush via timeout.
    bytes = {8'hA1, 8'hB2, 8'hC3};
    run_load(10'h200, 0, 1, 0, 0);
    chk("t3_tmo_literal", timeout, 1);
    chk("t3_mem200", mem[10'h200][23:0], 24'hC3B2A1);

    // Silence from the start: timeout with nothing to flush.
    bytes.delete();
    run_load(10'h210, 0, 1, 0, 0);
    chk("t3b_wc_literal", word_count, 0);

    // Start together with the first byte, plus a start pulse while busy.
    fill_rand(9);
    run_load(10'h040, 2, 0, 1, 1);

    // Reset asserted while the first word of a load is being written.
    bytes = {8'h01, 8'h02, 8'h03, 8'h04};
    model_load(10'h100, 0);
    base_addr = 10'h100;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b0, 1'b0, cyc);
    @(negedge clk);
    chk("t5_write_seen", ram_write, 1);
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    chk("t5_write_abandoned", mem[10'h100], 32'h0);
    fill_rand(6);
    run_load(0, 1, 0, 0, 0);

    // Randomised images, one of them near the RAM top.
    for (int k = 0; k < 10; k++) begin
      base = (k == 3) ? $urandom_range(1023, 1019) : $urandom_range(1000, 0);
      fill_rand($urandom_range(24, 1));
      run_load(base, 3, 0, $urandom_range(1, 0), 0);
    end

`ifdef LOADER_READBACK_VERIFY_EN
    corrupt = 1'b1;
    fill_rand(4);
    run_load(10'h020, 0, 0, 0, 0);
    chk("verify_err_set", verify_err, 1);
    corrupt = 1'b0;
    fill_rand(4);
    run_load(10'h020, 0, 0, 0, 0);
    chk("verify_err_clean", verify_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
